// File: rtl/matmul_seq_core_pkg.sv
// Shared definitions for the matmul sequencer core: state encoding and
// default operand/address widths.
package matmul_seq_core_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADR_W_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE_DOWN  = 2'b00,
      IDLE_UP    = 2'b01,
      DRAW_COL   = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: unsigned product truncated to DATA_W, added to
// the running sum unless the synchronous clear is high.
module mac_lane
   import matmul_seq_core_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc
);

   logic [DATA_W-1:0] acc_reg;
   logic [DATA_W-1:0] acc_next;
   logic [DATA_W-1:0] prod;

   assign prod     = a * b;
   assign acc_next = clear ? '0 : acc_reg + prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/matmul_seq_core.sv
// Sequencer for C = A x B: walks rows, column groups and the inner index,
// drives CORE_COUNT MAC lanes and strobes o_rst once per finished tile.
module matmul_seq_core
   import matmul_seq_core_pkg::*;
#(
   parameter int CORE_COUNT = 4,
   parameter int SIZE_ROW   = 6,
   parameter int SIZE_K     = 6,
   parameter int ADR_W      = ADR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic                         CLOCK_25,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [DATA_W-1:0]            i_a,
   input  logic [CORE_COUNT*DATA_W-1:0] i_b,
   output logic                         o_rst,
   output logic [ADR_W-1:0]             o_column_adr,
   output logic [ADR_W-1:0]             o_row_adr,
   output logic [ADR_W-1:0]             o_row_adr_pipe,
   output logic [ADR_W-1:0]             o_core_column,
   output logic [ADR_W-1:0]             o_core_column_pipe,
   output logic [CORE_COUNT*DATA_W-1:0] o_acc,
   output logic [1:0]                   o_state
);

   localparam logic [ADR_W-1:0] K_LAST   = ADR_W'(SIZE_K - 1);
   localparam logic [ADR_W-1:0] ROW_LAST = ADR_W'(SIZE_ROW - 1);
   localparam logic [ADR_W:0]   GROUP_W  = (ADR_W + 1)'(CORE_COUNT);
   localparam logic [ADR_W:0]   ROW_LIM  = (ADR_W + 1)'(SIZE_ROW);

   state_t           state_reg, state_next;
   logic             rst_reg, rst_next;
   logic [ADR_W-1:0] column_reg, column_next;
   logic [ADR_W-1:0] row_reg, row_next;
   logic [ADR_W-1:0] core_col_reg, core_col_next;
   logic [ADR_W-1:0] row_pipe_reg, row_pipe_next;
   logic [ADR_W-1:0] col_pipe_reg, col_pipe_next;

   // One extra bit so the group advance cannot wrap before the limit compare.
   logic [ADR_W:0]   core_sum;
   logic             last_group;

   assign core_sum   = {1'b0, core_col_reg} + GROUP_W;
   assign last_group = (core_sum >= ROW_LIM);

   always_ff @(posedge CLOCK_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE_DOWN;
         rst_reg      <= 1'b1;
         column_reg   <= '0;
         row_reg      <= '0;
         core_col_reg <= '0;
         row_pipe_reg <= '0;
         col_pipe_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rst_reg      <= rst_next;
         column_reg   <= column_next;
         row_reg      <= row_next;
         core_col_reg <= core_col_next;
         row_pipe_reg <= row_pipe_next;
         col_pipe_reg <= col_pipe_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rst_next      = rst_reg;
      column_next   = column_reg;
      row_next      = row_reg;
      core_col_next = core_col_reg;
      row_pipe_next = row_pipe_reg;
      col_pipe_next = col_pipe_reg;

      case (state_reg)
         IDLE_DOWN: begin
            rst_next = 1'b1;
            if (start) begin
               state_next = IDLE_UP;
            end
         end
         IDLE_UP: begin
            rst_next = 1'b1;
            if (!start) begin
               state_next    = DRAW_COL;
               rst_next      = 1'b0;
               column_next   = '0;
               row_next      = '0;
               core_col_next = '0;
            end
         end
         DRAW_COL: begin
            if (!rst_reg) begin
               if (column_reg < K_LAST) begin
                  column_next = column_reg + ADR_W'(1);
               end else begin
                  rst_next      = 1'b1;
                  row_pipe_next = row_reg;
                  col_pipe_next = core_col_reg;
               end
            end else begin
               // Flush cycle: lanes clear while the writer stores the tile.
               column_next = '0;
               if (last_group) begin
                  core_col_next = '0;
                  row_next      = row_reg + ADR_W'(1);
               end else begin
                  core_col_next = core_sum[ADR_W-1:0];
               end
               if (last_group && (row_reg == ROW_LAST)) begin
                  state_next = IDLE_DOWN;
                  rst_next   = 1'b1;
               end else begin
                  rst_next = 1'b0;
               end
            end
         end
         default: begin
            state_next = IDLE_DOWN;
            rst_next   = 1'b1;
         end
      endcase
   end

   for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_lane
      mac_lane #(
         .DATA_W (DATA_W)
      ) u_lane (
         .clk   (CLOCK_25),
         .rst_n (rst_n),
         .clear (rst_reg),
         .a     (i_a),
         .b     (i_b[gi*DATA_W +: DATA_W]),
         .acc   (o_acc[gi*DATA_W +: DATA_W])
      );
   end

   assign o_rst              = rst_reg;
   assign o_column_adr       = column_reg;
   assign o_row_adr          = row_reg;
   assign o_row_adr_pipe     = row_pipe_reg;
   assign o_core_column      = core_col_reg;
   assign o_core_column_pipe = col_pipe_reg;
   assign o_state            = state_reg;

endmodule

// File: tb/tb_matmul_seq_core.sv
// Self-checking bench for matmul_seq_core: operand memories, a plain matrix
// product reference, per-tile scoreboard, timing and handshake checks.
module tb_matmul_seq_core;

   localparam int CC = 4;
   localparam int N  = 6;
   localparam int K  = 6;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [DW-1:0]     i_a;
   logic [CC*DW-1:0]  i_b;
   logic              o_rst;
   logic [AW-1:0]     o_column_adr;
   logic [AW-1:0]     o_row_adr;
   logic [AW-1:0]     o_row_adr_pipe;
   logic [AW-1:0]     o_core_column;
   logic [AW-1:0]     o_core_column_pipe;
   logic [CC*DW-1:0]  o_acc;
   logic [1:0]        o_state;

   matmul_seq_core #(
      .CORE_COUNT (CC),
      .SIZE_ROW   (N),
      .SIZE_K     (K),
      .ADR_W      (AW),
      .DATA_W     (DW)
   ) dut (
      .CLOCK_25           (clk),
      .rst_n              (rst_n),
      .start              (start),
      .i_a                (i_a),
      .i_b                (i_b),
      .o_rst              (o_rst),
      .o_column_adr       (o_column_adr),
      .o_row_adr          (o_row_adr),
      .o_row_adr_pipe     (o_row_adr_pipe),
      .o_core_column      (o_core_column),
      .o_core_column_pipe (o_core_column_pipe),
      .o_acc              (o_acc),
      .o_state            (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand memories; B has two spare columns feeding the don't-care lanes.
   logic [DW-1:0] mem_a [0:N-1][0:K-1];
   logic [DW-1:0] mem_b [0:K-1][0:N+1];
   logic [DW-1:0] c_ref [0:N-1][0:N-1];
   logic [DW-1:0] cap   [0:N-1][0:N-1];

   always_comb begin
      i_a = '0;
      i_b = '0;
      if (int'(o_row_adr) < N && int'(o_column_adr) < K)
         i_a = mem_a[int'(o_row_adr)][int'(o_column_adr)];
      for (int g = 0; g < CC; g++) begin
         if (int'(o_column_adr) < K && int'(o_core_column) + g < N + 2)
            i_b[g*DW +: DW] = mem_b[int'(o_column_adr)][int'(o_core_column) + g];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic build_ref();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            logic [DW-1:0] s;
            s = '0;
            for (int k = 0; k < K; k++) s = s + mem_a[i][k] * mem_b[k][j];
            c_ref[i][j] = s;
         end
      end
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) mem_a[i][k] = DW'(6*i + k + 1);
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N + 2; j++) mem_b[k][j] = DW'(6*j + k + 1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) mem_a[i][k] = $urandom;
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N + 2; j++) mem_b[k][j] = $urandom;
   endtask

   task automatic clear_cap();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) cap[i][j] = 32'hDEAD_BEEF;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_state"}, o_state, 2'b00);
      chk({tag, "_rst"}, o_rst, 1'b1);
      chk({tag, "_col"}, o_column_adr, 0);
      chk({tag, "_row"}, o_row_adr, 0);
      chk({tag, "_core"}, o_core_column, 0);
      chk({tag, "_rowpipe"}, o_row_adr_pipe, 0);
      chk({tag, "_colpipe"}, o_core_column_pipe, 0);
      chk({tag, "_acc"}, o_acc, 0);
   endtask

   // Press/release, then follow the run cycle by cycle (cycle 1 = first
   // DRAW_COL cycle). abort_at>0 pulls rst_n low in that cycle.
   task automatic do_run(input int abort_at, input bit toggle);
      int  cyc;
      int  strobes;
      bit  prev;
      bit  done;
      clear_cap();
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("press_state", o_state, 2'b01);
      chk("press_rst", o_rst, 1'b1);
      start = 1'b0;
      @(negedge clk);
      chk("enter_state", o_state, 2'b10);
      chk("enter_rst", o_rst, 1'b0);
      cyc = 1; prev = 1'b0; strobes = 0; done = 1'b0;
      while (!done && cyc < 200) begin
         if (toggle && cyc > 1 && cyc < 70) start = 1'($urandom_range(0, 1));
         else start = 1'b0;
         if (o_rst && !prev) begin
            int rp, cp;
            rp = int'(o_row_adr_pipe);
            cp = int'(o_core_column_pipe);
            chk("strobe_cycle", cyc, 7 * (strobes + 1));
            chk("row_pipe", rp, strobes / 2);
            chk("col_pipe", cp, (strobes % 2) * CC);
            for (int g = 0; g < CC; g++) begin
               if (rp < N && cp + g < N) begin
                  cap[rp][cp + g] = o_acc[g*DW +: DW];
                  chk($sformatf("acc_r%0d_c%0d", rp, cp + g), o_acc[g*DW +: DW], c_ref[rp][cp + g]);
               end
            end
            $display("tile %0d: row %0d col %0d cycle %0d", strobes, rp, cp, cyc);
            strobes++;
         end
         prev = o_rst;
         if (cyc == abort_at) begin
            #1 rst_n = 1'b0;
            #1 chk_reset_state("abort");
            @(negedge clk);
            chk_reset_state("abort_hold");
            rst_n = 1'b1;
            chk("abort_strobes", strobes, abort_at / 7);
            return;
         end
         @(negedge clk);
         cyc++;
         if (o_state == 2'b00) done = 1'b1;
      end
      start = 1'b0;
      chk("run_end_cycle", cyc, 85);
      chk("run_strobes", strobes, 12);
      chk("run_end_rst", o_rst, 1'b1);
   endtask

   typedef struct {
      int            row;
      int            col;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t tbl [6];

   task automatic chk_table(input string tag);
      for (int v = 0; v < 6; v++)
         chk($sformatf("%s_C%0d%0d", tag, tbl[v].row, tbl[v].col),
             cap[tbl[v].row][tbl[v].col], tbl[v].exp);
   endtask

   initial begin
      tbl[0] = '{0, 0, 32'd91};
      tbl[1] = '{0, 1, 32'd217};
      tbl[2] = '{0, 2, 32'd343};
      tbl[3] = '{1, 0, 32'd217};
      tbl[4] = '{5, 4, 32'd5545};
      tbl[5] = '{5, 5, 32'd6751};

      rst_n = 1'b0;
      start = 1'b0;
      fill_pattern();
      build_ref();
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_start", o_state, 2'b00);

      do_run(0, 1'b0);
      chk_table("det");
      repeat (5) @(negedge clk);
      chk("no_rerun_state", o_state, 2'b00);

      do_run(30, 1'b0);
      @(negedge clk);
      chk("after_abort_state", o_state, 2'b00);
      do_run(0, 1'b0);
      chk_table("rerun");

      for (int r = 0; r < 2; r++) begin
         fill_random();
         build_ref();
         do_run(0, 1'b1);
         repeat (2) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
